// File: rtl/ahb_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_matrix_pkg
//  Description : Shared AHB encodings and address-phase control bundle for the
//                L1 AHB matrix (input stages, decoders, output stages).
//                Optional build macro AHB_INSTAGE_SEQ2NONSEQ_EN changes how a
//                transfer replayed from a holding register is re-encoded.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_matrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    // Address-phase control bundle (everything except select and address).
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } ahb_ctrl_t;

    // Re-encoding applied to a transfer when it is issued from the holding
    // register. With the macro defined, a held transfer may be separated
    // from its burst by arbitration, so it is restarted as an undefined-
    // length burst: SEQ becomes NONSEQ and fixed bursts become INCR.
    function automatic ahb_ctrl_t held_issue_ctrl(input ahb_ctrl_t c);
        ahb_ctrl_t r;
        r = c;
`ifdef AHB_INSTAGE_SEQ2NONSEQ_EN
        if (c.trans == HTRANS_SEQ) begin
            r.trans = HTRANS_NONSEQ;
        end
        if (c.burst != HBURST_SINGLE) begin
            r.burst = HBURST_INCR;
        end
`endif
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_matrix_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_matrix_hold_reg
//  Description : Address-phase holding register plus the address mux that
//                selects between the held transfer and the live master bus.
//  Ports       : HCLK/HRESETn   clock, async active-low reset
//                capture_i      load live address phase into holding register
//                release_i      held transfer is issued this cycle
//                live_*_i       live master select/address/control
//                hold_valid_o   holding register full
//                sel_o/addr_o/ctrl_o  muxed address phase towards decoder
//  Macro       : AHB_INSTAGE_SEQ2NONSEQ_EN (via held_issue_ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_matrix_hold_reg
    import ahb_matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  capture_i,
    input  logic                  release_i,
    input  logic                  live_sel_i,
    input  logic [ADDR_WIDTH-1:0] live_addr_i,
    input  ahb_ctrl_t             live_ctrl_i,
    output logic                  hold_valid_o,
    output logic                  sel_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output ahb_ctrl_t             ctrl_o
);

    logic                  hold_valid_q;
    logic                  hold_valid_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    ahb_ctrl_t             hold_ctrl_q;

    // Capture is only honoured while empty; a full register can only drain.
    assign hold_valid_d = hold_valid_q ? ~release_i : capture_i;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_ctrl_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            if (capture_i && !hold_valid_q) begin
                hold_addr_q <= live_addr_i;
                hold_ctrl_q <= live_ctrl_i;
            end
        end
    end

    always_comb begin
        sel_o  = live_sel_i;
        addr_o = live_addr_i;
        ctrl_o = live_ctrl_i;
        if (hold_valid_q) begin
            sel_o  = 1'b1;
            addr_o = hold_addr_q;
            ctrl_o = held_issue_ctrl(hold_ctrl_q);
        end else if (!live_sel_i) begin
            // Unselected port presents IDLE so the decoder never sees a
            // stray active transfer type.
            ctrl_o.trans = HTRANS_IDLE;
        end
    end

    assign hold_valid_o = hold_valid_q;

endmodule
`default_nettype wire

// File: rtl/ahb_matrix_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_matrix_input_stage
//  Description : Slave-side input stage of the L1 AHB matrix (one per master
//                port). Buffers an address phase whenever the target output
//                stage is not active and stalls the master until it issues.
//  Ports       : HCLK/HRESETn         clock, async active-low reset
//                H*S inputs           master address phase, HREADYS
//                HREADYOUTS/HRESPS    data-phase response to master
//                *_op outputs         address phase and HREADY to decoder
//                active_op/readyout_op/resp_op  decoder status/response
//  Macro       : AHB_INSTAGE_SEQ2NONSEQ_EN - held SEQ issues as NONSEQ and
//                held non-SINGLE bursts issue as INCR.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_matrix_input_stage
    import ahb_matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DECODE_LSB = 10
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             HSELS,
    input  logic [ADDR_WIDTH-1:0]            HADDRS,
    input  logic [1:0]                       HTRANSS,
    input  logic                             HWRITES,
    input  logic [2:0]                       HSIZES,
    input  logic [2:0]                       HBURSTS,
    input  logic [3:0]                       HPROTS,
    input  logic                             HMASTLOCKS,
    input  logic                             HREADYS,
    output logic                             HREADYOUTS,
    output logic [1:0]                       HRESPS,
    output logic                             sel_op,
    output logic [ADDR_WIDTH-1:0]            addr_op,
    output logic [ADDR_WIDTH-DECODE_LSB-1:0] decode_addr_op,
    output logic [1:0]                       trans_op,
    output logic                             write_op,
    output logic [2:0]                       size_op,
    output logic [2:0]                       burst_op,
    output logic [3:0]                       prot_op,
    output logic                             lock_op,
    output logic                             held_tran_op,
    output logic                             ready_op,
    input  logic                             active_op,
    input  logic                             readyout_op,
    input  logic [1:0]                       resp_op
);

    ahb_ctrl_t w_live_ctrl;
    ahb_ctrl_t w_mux_ctrl;
    logic      w_load;
    logic      w_capture;
    logic      w_release;
    logic      w_hold_valid;
    logic      dphase_q;
    logic      dphase_d;

    assign w_live_ctrl = '{trans: HTRANSS, write: HWRITES, size: HSIZES,
                           burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

    assign w_load    = HSELS & HTRANSS[1] & HREADYS;
    assign w_capture = w_load & ~active_op;
    assign w_release = active_op & ready_op;

    ahb_matrix_hold_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_reg (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .capture_i    (w_capture),
        .release_i    (w_release),
        .live_sel_i   (HSELS),
        .live_addr_i  (HADDRS),
        .live_ctrl_i  (w_live_ctrl),
        .hold_valid_o (w_hold_valid),
        .sel_o        (sel_op),
        .addr_o       (addr_op),
        .ctrl_o       (w_mux_ctrl)
    );

    assign decode_addr_op = addr_op[ADDR_WIDTH-1:DECODE_LSB];
    assign trans_op       = w_mux_ctrl.trans;
    assign write_op       = w_mux_ctrl.write;
    assign size_op        = w_mux_ctrl.size;
    assign burst_op       = w_mux_ctrl.burst;
    assign prot_op        = w_mux_ctrl.prot;
    assign lock_op        = w_mux_ctrl.lock;
    assign held_tran_op   = w_hold_valid;

    // While holding, the master's HREADY is forced low, so the decoder's
    // HREADY is generated locally: the held address phase may advance once
    // any forwarded data phase ahead of it has completed.
    assign ready_op = w_hold_valid ? (~dphase_q | readyout_op) : HREADYS;

    assign dphase_d = ready_op ? (sel_op & trans_op[1] & active_op) : dphase_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_q <= 1'b0;
        end else begin
            dphase_q <= dphase_d;
        end
    end

    assign HREADYOUTS = w_hold_valid ? 1'b0 : (dphase_q ? readyout_op : 1'b1);
    assign HRESPS     = (dphase_q & ~w_hold_valid) ? resp_op : HRESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_ahb_matrix_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_matrix_input_stage
//  Description : Self-checking bench for ahb_matrix_input_stage: directed
//                scenarios plus randomized traffic against a queue-based
//                reference model. Honours AHB_INSTAGE_SEQ2NONSEQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_matrix_input_stage;

    localparam int AW = 32;
    localparam int DL = 10;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic          sel_op;
    logic [AW-1:0] addr_op;
    logic [AW-DL-1:0] decode_addr_op;
    logic [1:0]    trans_op;
    logic          write_op;
    logic [2:0]    size_op;
    logic [2:0]    burst_op;
    logic [3:0]    prot_op;
    logic          lock_op;
    logic          held_tran_op;
    logic          ready_op;
    logic          active_op;
    logic          readyout_op;
    logic [1:0]    resp_op;

    int checks   = 0;
    int failures = 0;

    ahb_matrix_input_stage #(.ADDR_WIDTH(AW), .DECODE_LSB(DL)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_op(sel_op), .addr_op(addr_op), .decode_addr_op(decode_addr_op),
        .trans_op(trans_op), .write_op(write_op), .size_op(size_op),
        .burst_op(burst_op), .prot_op(prot_op), .lock_op(lock_op),
        .held_tran_op(held_tran_op), .ready_op(ready_op),
        .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op)
    );

    always #5 HCLK = ~HCLK;

    // {sel, trans[1:0], held, hreadyout, hresp[1:0], ready_op}
    wire [7:0] w_obs = {sel_op, trans_op, held_tran_op, HREADYOUTS, HRESPS, ready_op};

    // A new address phase must never be accepted while one is held.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && held_tran_op === 1'b1) begin
            checks++;
            if (HSELS && HTRANSS[1] && HREADYS) begin
                failures++;
                $display("FAIL load_while_held t=%0t HSELS=%b HTRANSS=%b HREADYS=%b required HREADYS=0",
                         $time, HSELS, HTRANSS, HREADYS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a transfer waits in a one-entry queue until the
    // decoder grants it; a single bit tracks a forwarded data phase.
    // ------------------------------------------------------------------
    typedef struct {
        logic          sel;
        logic [1:0]    trans;
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          lock;
    } ap_t;

    ap_t  m_hold[$];
    bit   m_dph;
    ap_t  e_ap;
    logic e_held, e_hro, e_ready;
    logic [1:0] e_resp;

    task automatic model_eval();
        if (m_hold.size() != 0) begin
            e_ap = m_hold[0];
            e_ap.sel = 1'b1;
`ifdef AHB_INSTAGE_SEQ2NONSEQ_EN
            if (e_ap.trans == 2'b11) e_ap.trans = 2'b10;
            if (e_ap.burst != 3'b000) e_ap.burst = 3'b001;
`endif
            e_held  = 1'b1;
            e_hro   = 1'b0;
            e_resp  = 2'b00;
            e_ready = !m_dph || readyout_op;
        end else begin
            e_ap = '{HSELS, HSELS ? HTRANSS : 2'b00, HADDRS, HWRITES, HSIZES,
                     HBURSTS, HPROTS, HMASTLOCKS};
            e_held  = 1'b0;
            e_hro   = m_dph ? readyout_op : 1'b1;
            e_resp  = m_dph ? resp_op : 2'b00;
            e_ready = HREADYS;
        end
    endtask

    task automatic model_edge();
        bit  issued, load;
        ap_t live;
        model_eval();
        issued = e_ap.sel && e_ap.trans[1] && active_op;
        load   = HSELS && HTRANSS[1] && HREADYS;
        live   = '{HSELS, HTRANSS, HADDRS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
        if (m_hold.size() != 0) begin
            if (active_op && e_ready) void'(m_hold.pop_front());
        end else if (load && !active_op) begin
            m_hold.push_back(live);
        end
        if (e_ready) m_dph = issued;
    endtask

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_ap(input logic sel, input logic [1:0] trans,
                            input logic [AW-1:0] addr, input logic [2:0] burst);
        HSELS = sel; HTRANSS = trans; HADDRS = addr; HBURSTS = burst;
        HWRITES = addr[2]; HSIZES = 3'd2; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        HRESETn = 1'b0;
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        HREADYS = 1'b1; active_op = 1'b0; readyout_op = 1'b1; resp_op = 2'b00;
        #3;
        checks++;
        if (w_obs !== 8'h09) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=%h", w_obs, 8'h09);
        end
        HREADYS = 1'b0;
        #1;
        checks++;
        if (w_obs !== 8'h08) begin
            failures++;
            $display("FAIL reset_ready_follow got=%h required=%h", w_obs, 8'h08);
        end
        HREADYS = 1'b1;
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_nonseq_pass();
        drive_ap(1'b1, 2'b10, 32'h0000_1000, 3'b000);
        active_op = 1'b1; readyout_op = 1'b1; HREADYS = 1'b1;
        #2;
        checks++;
        if ({w_obs, addr_op, decode_addr_op} !== {8'hC9, 32'h0000_1000, 22'h4}) begin
            failures++;
            $display("FAIL pass_addr obs=%h addr=%h dec=%h required C9/00001000/4",
                     w_obs, addr_op, decode_addr_op);
        end
        tick();
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        #2;
        checks++;
        if (w_obs !== 8'h09) begin
            failures++;
            $display("FAIL pass_dphase got=%h required=%h", w_obs, 8'h09);
        end
        tick();
    endtask

    task automatic test_hold();
        drive_ap(1'b1, 2'b10, 32'h0000_2004, 3'b000);
        active_op = 1'b0; readyout_op = 1'b1; HREADYS = 1'b1;
        #2;
        checks++;
        if (w_obs !== 8'hC9) begin
            failures++;
            $display("FAIL hold_load_cycle got=%h required=%h", w_obs, 8'hC9);
        end
        tick();
        drive_ap(1'b0, 2'b00, 32'hDEAD_0000, 3'b000);
        HREADYS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({w_obs, addr_op, write_op} !== {8'hD1, 32'h0000_2004, 1'b1}) begin
                failures++;
                $display("FAIL hold_wait[%0d] obs=%h addr=%h wr=%b required D1/00002004/1",
                         i, w_obs, addr_op, write_op);
            end
            tick();
        end
        active_op = 1'b1;
        #2;
        checks++;
        if (w_obs !== 8'hD1) begin
            failures++;
            $display("FAIL hold_issue got=%h required=%h", w_obs, 8'hD1);
        end
        tick();
        HREADYS = 1'b1;
        #2;
        checks++;
        if (w_obs !== 8'h09) begin
            failures++;
            $display("FAIL hold_dphase_ready got=%h required=%h", w_obs, 8'h09);
        end
        readyout_op = 1'b0; HREADYS = 1'b0;
        #1;
        checks++;
        if (w_obs !== 8'h00) begin
            failures++;
            $display("FAIL hold_dphase_wait got=%h required=%h", w_obs, 8'h00);
        end
        readyout_op = 1'b1; HREADYS = 1'b1;
        tick();
    endtask

    task automatic test_wait_states();
        drive_ap(1'b1, 2'b10, 32'h0000_3000, 3'b000);
        active_op = 1'b1; readyout_op = 1'b1; HREADYS = 1'b1;
        tick();
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        readyout_op = 1'b0; HREADYS = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (w_obs !== 8'h00) begin
                failures++;
                $display("FAIL wait_state[%0d] got=%h required=%h", i, w_obs, 8'h00);
            end
            tick();
        end
        readyout_op = 1'b1; HREADYS = 1'b1;
        #2;
        checks++;
        if (w_obs !== 8'h09) begin
            failures++;
            $display("FAIL wait_done got=%h required=%h", w_obs, 8'h09);
        end
        tick();
    endtask

    task automatic test_error();
        drive_ap(1'b1, 2'b10, 32'h0000_4000, 3'b000);
        active_op = 1'b1; readyout_op = 1'b1; HREADYS = 1'b1;
        tick();
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        readyout_op = 1'b0; resp_op = 2'b01; HREADYS = 1'b0;
        #2;
        checks++;
        if (w_obs !== 8'h02) begin
            failures++;
            $display("FAIL error_cycle1 got=%h required=%h", w_obs, 8'h02);
        end
        tick();
        readyout_op = 1'b1; HREADYS = 1'b1;
        #2;
        checks++;
        if (w_obs !== 8'h0B) begin
            failures++;
            $display("FAIL error_cycle2 got=%h required=%h", w_obs, 8'h0B);
        end
        tick();
        // No data phase now: a stray decoder ERROR must not reach the master.
        #2;
        checks++;
        if (w_obs !== 8'h09) begin
            failures++;
            $display("FAIL error_no_dphase got=%h required=%h", w_obs, 8'h09);
        end
        resp_op = 2'b00;
        tick();
    endtask

    task automatic test_held_seq();
        logic [1:0] exp_trans;
        logic [2:0] exp_burst;
`ifdef AHB_INSTAGE_SEQ2NONSEQ_EN
        exp_trans = 2'b10; exp_burst = 3'b001;
`else
        exp_trans = 2'b11; exp_burst = 3'b011;
`endif
        drive_ap(1'b1, 2'b11, 32'h0000_5008, 3'b011);
        active_op = 1'b0; readyout_op = 1'b1; HREADYS = 1'b1;
        tick();
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        HREADYS = 1'b0;
        #2;
        checks++;
        if ({trans_op, burst_op, held_tran_op} !== {exp_trans, exp_burst, 1'b1}) begin
            failures++;
            $display("FAIL held_seq trans=%b burst=%b held=%b required %b/%b/1",
                     trans_op, burst_op, held_tran_op, exp_trans, exp_burst);
        end
        active_op = 1'b1;
        tick();
        HREADYS = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        drive_ap(1'b1, 2'b10, 32'h0000_6000, 3'b000);
        active_op = 1'b0; readyout_op = 1'b1; HREADYS = 1'b1;
        tick();
        drive_ap(1'b0, 2'b00, '0, 3'b000);
        HREADYS = 1'b0;
        #2;
        checks++;
        if (w_obs !== 8'hD1) begin
            failures++;
            $display("FAIL midhold_held got=%h required=%h", w_obs, 8'hD1);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (w_obs !== 8'h08) begin
            failures++;
            $display("FAIL midhold_async_reset got=%h required=%h", w_obs, 8'h08);
        end
        active_op = 1'b1;
        tick();
        tick();
        HRESETn = 1'b1; HREADYS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (w_obs !== 8'h09) begin
                failures++;
                $display("FAIL midhold_after_release[%0d] got=%h required=%h", i, w_obs, 8'h09);
            end
            tick();
        end
    endtask

    task automatic test_random();
        HRESETn = 1'b0;
        m_hold.delete();
        m_dph = 1'b0;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 400; i++) begin
            HSELS       = ($urandom_range(0, 3) != 0);
            HTRANSS     = 2'($urandom_range(0, 3));
            HADDRS      = $urandom;
            HWRITES     = 1'($urandom_range(0, 1));
            HSIZES      = 3'($urandom_range(0, 7));
            HBURSTS     = 3'($urandom_range(0, 7));
            HPROTS      = 4'($urandom_range(0, 15));
            HMASTLOCKS  = 1'($urandom_range(0, 1));
            active_op   = ($urandom_range(0, 3) != 0);
            readyout_op = ($urandom_range(0, 3) != 0);
            resp_op     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            model_eval();
            HREADYS = e_hro;   // single master: bus HREADY is our own HREADYOUT
            model_eval();
            #2;
            checks++;
            if (w_obs !== {e_ap.sel, e_ap.trans, e_held, e_hro, e_resp, e_ready}) begin
                failures++;
                $display("FAIL rand_status[%0d] got=%h required=%h", i, w_obs,
                         {e_ap.sel, e_ap.trans, e_held, e_hro, e_resp, e_ready});
            end
            checks++;
            if ({addr_op, write_op, size_op, burst_op, prot_op, lock_op} !==
                {e_ap.addr, e_ap.write, e_ap.size, e_ap.burst, e_ap.prot, e_ap.lock}) begin
                failures++;
                $display("FAIL rand_addrphase[%0d] got=%h/%b/%h/%h/%h/%b required=%h/%b/%h/%h/%h/%b",
                         i, addr_op, write_op, size_op, burst_op, prot_op, lock_op,
                         e_ap.addr, e_ap.write, e_ap.size, e_ap.burst, e_ap.prot, e_ap.lock);
            end
            model_edge();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nonseq_pass();
        test_hold();
        test_wait_states();
        test_error();
        test_held_seq();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
